dma_handshake_monitor: RTL and testbench

Synthesizable, parametrised monitor for the DMA controller's DREQ/DACK and IOR_N/IOW_N bus protocol.
- Generalises the 4-channel cover/assert checker to NUM_CH channels.
- Adds per-channel handshake FSMs, saturating event counters, request-timeout detection and sticky error reporting.
- Binds beside the controller; also usable on silicon debug paths.

---
 rtl/dma_mon_pkg.sv | 32 +++
 rtl/dma_mon_channel.sv | 109 ++++++++++
 rtl/dma_handshake_monitor.sv | 119 +++++++++++
 tb/tb_dma_handshake_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_mon_pkg.sv
// Shared state type, error indices and small helpers for the DMA DREQ/DACK handshake monitor.
// Latency: none, pure declarations. Backpressure: none; the monitor only observes the bus.
package dma_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      ACK  = 2'd2
   } ch_state_e;

   localparam int ERR_W        = 5;
   localparam int E_ACK_NO_REQ = 0;
   localparam int E_MULTI_ACK  = 1;
   localparam int E_IO_BOTH    = 2;
   localparam int E_TIMEOUT    = 3;
   localparam int E_REQ_DROP   = 4;

   // True when at most one bit is set.
   function automatic logic onehot0(input logic [7:0] v);
      return (v & (v - 8'd1)) == 8'd0;
   endfunction

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) r = 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/dma_mon_channel.sv
// Per-channel DREQ/DACK handshake FSM with timeout detection and saturating request/ack counters.
// Latency: event strobes combinational, counters update at posedge. Backpressure: none; observe only.
module dma_mon_channel
   import dma_mon_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             dreq,
   input  logic             dack,
   output logic [CNT_W-1:0] req_cnt,
   output logic [CNT_W-1:0] ack_cnt,
   output logic             ack_no_req_evt,
   output logic             timeout_evt,
   output logic             req_drop_evt
);
   localparam int              TO_W   = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

   ch_state_e        state_q, state_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0] ack_cnt_q, ack_cnt_d;
   logic             req_inc, ack_inc;

   always_comb begin
      state_d        = state_q;
      req_inc        = 1'b0;
      ack_inc        = 1'b0;
      ack_no_req_evt = 1'b0;
      req_drop_evt   = 1'b0;
      case (state_q)
         IDLE: begin
            if (dreq) begin
               req_inc = 1'b1;
               if (dack) begin
                  state_d = ACK;
                  ack_inc = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end else if (dack) begin
               ack_no_req_evt = 1'b1;
            end
         end
         REQ: begin
            if (dack) begin
               state_d = ACK;
               ack_inc = 1'b1;
            end else if (!dreq) begin
               state_d      = IDLE;
               req_drop_evt = 1'b1;
            end
         end
         ACK: begin
            if (!dack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Timer restarts on every entry to REQ and parks at TIMEOUT so the event fires once.
      to_cnt_d    = '0;
      timeout_evt = 1'b0;
      if (state_q == REQ && state_d == REQ) begin
         to_cnt_d    = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TO_W'(1);
         timeout_evt = (to_cnt_q == TO_MAX - TO_W'(1));
      end

      req_cnt_d = req_cnt_q;
      ack_cnt_d = ack_cnt_q;
      if (clr) begin
         req_cnt_d = '0;
         ack_cnt_d = '0;
      end else begin
         if (req_inc && req_cnt_q != '1) req_cnt_d = req_cnt_q + CNT_W'(1);
         if (ack_inc && ack_cnt_q != '1) ack_cnt_d = ack_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         to_cnt_q  <= '0;
         req_cnt_q <= '0;
         ack_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         to_cnt_q  <= to_cnt_d;
         req_cnt_q <= req_cnt_d;
         ack_cnt_q <= ack_cnt_d;
      end
   end

   assign req_cnt = req_cnt_q;
   assign ack_cnt = ack_cnt_q;

`ifdef DMA_MON_ASSERT_EN
   c_dack_only: cover property (@(posedge clk) disable iff (!rst_n) dack && !dreq);
   c_idle_req:  cover property (@(posedge clk) disable iff (!rst_n) state_q == IDLE && state_d == REQ);
   c_idle_ack:  cover property (@(posedge clk) disable iff (!rst_n) state_q == IDLE && state_d == ACK);
   c_req_ack:   cover property (@(posedge clk) disable iff (!rst_n) state_q == REQ && state_d == ACK);
   c_req_idle:  cover property (@(posedge clk) disable iff (!rst_n) state_q == REQ && state_d == IDLE);
   c_ack_idle:  cover property (@(posedge clk) disable iff (!rst_n) state_q == ACK && state_d == IDLE);
`endif

endmodule

// File: rtl/dma_handshake_monitor.sv
// NUM_CH-channel DREQ/DACK + IOR_N/IOW_N monitor: counters, sticky errors, first-error capture; 1-cycle error latency, no backpressure.
// Define DMA_MON_ASSERT_EN to elaborate per-error SVA asserts and per-channel covers.
module dma_handshake_monitor
   import dma_mon_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                    CLK,
   input  logic                    RESET_N,
   input  logic [NUM_CH-1:0]       DREQ,
   input  logic [NUM_CH-1:0]       DACK,
   input  logic                    IOR_N,
   input  logic                    IOW_N,
   input  logic                    CLR,
   output logic [NUM_CH*CNT_W-1:0] REQ_CNT,
   output logic [NUM_CH*CNT_W-1:0] ACK_CNT,
   output logic [ERR_W-1:0]        ERR_FLAGS,
   output logic                    ERR_VALID,
   output logic [2:0]              FIRST_ERR_CH,
   output logic [2:0]              FIRST_ERR_CODE
);
   logic [NUM_CH-1:0] ack_no_req_v, timeout_v, req_drop_v;
   logic [ERR_W-1:0]  ev;
   logic [2:0]        ch_of [ERR_W];
   logic [2:0]        ev_ch, ev_code;

   logic [ERR_W-1:0]  err_flags_q, err_flags_d;
   logic              err_valid_q, err_valid_d;
   logic [2:0]        first_ch_q, first_ch_d;
   logic [2:0]        first_code_q, first_code_d;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      dma_mon_channel #(
         .CNT_W   (CNT_W),
         .TIMEOUT (TIMEOUT)
      ) u_ch (
         .clk            (CLK),
         .rst_n          (RESET_N),
         .clr            (CLR),
         .dreq           (DREQ[i]),
         .dack           (DACK[i]),
         .req_cnt        (REQ_CNT[i*CNT_W +: CNT_W]),
         .ack_cnt        (ACK_CNT[i*CNT_W +: CNT_W]),
         .ack_no_req_evt (ack_no_req_v[i]),
         .timeout_evt    (timeout_v[i]),
         .req_drop_evt   (req_drop_v[i])
      );
   end

   always_comb begin
      ev[E_ACK_NO_REQ] = |ack_no_req_v;
      ev[E_MULTI_ACK]  = !onehot0(8'(DACK));
      ev[E_IO_BOTH]    = !IOR_N && !IOW_N;
      ev[E_TIMEOUT]    = |timeout_v;
      ev[E_REQ_DROP]   = |req_drop_v;

      // Bus-wide errors have no owning channel and report as channel 0.
      ch_of[E_ACK_NO_REQ] = lowest_set(8'(ack_no_req_v));
      ch_of[E_MULTI_ACK]  = 3'd0;
      ch_of[E_IO_BOTH]    = 3'd0;
      ch_of[E_TIMEOUT]    = lowest_set(8'(timeout_v));
      ch_of[E_REQ_DROP]   = lowest_set(8'(req_drop_v));

      ev_code = 3'd0;
      ev_ch   = 3'd0;
      for (int k = ERR_W - 1; k >= 0; k--) begin
         if (ev[k]) begin
            ev_code = 3'(k);
            ev_ch   = ch_of[k];
         end
      end
   end

   always_comb begin
      err_flags_d  = err_flags_q | ev;
      err_valid_d  = |ev;
      first_ch_d   = first_ch_q;
      first_code_d = first_code_q;
      if (err_flags_q == '0 && |ev) begin
         first_ch_d   = ev_ch;
         first_code_d = ev_code;
      end
      if (CLR) begin
         err_flags_d  = '0;
         err_valid_d  = 1'b0;
         first_ch_d   = 3'd0;
         first_code_d = 3'd0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         err_flags_q  <= '0;
         err_valid_q  <= 1'b0;
         first_ch_q   <= 3'd0;
         first_code_q <= 3'd0;
      end else begin
         err_flags_q  <= err_flags_d;
         err_valid_q  <= err_valid_d;
         first_ch_q   <= first_ch_d;
         first_code_q <= first_code_d;
      end
   end

   assign ERR_FLAGS      = err_flags_q;
   assign ERR_VALID      = err_valid_q;
   assign FIRST_ERR_CH   = first_ch_q;
   assign FIRST_ERR_CODE = first_code_q;

`ifdef DMA_MON_ASSERT_EN
   for (genvar k = 0; k < ERR_W; k++) begin : g_err_sva
      a_no_err: assert property (@(posedge CLK) disable iff (!RESET_N) !ev[k])
         else $error("dma_handshake_monitor: error code %0d on channel %0d", k, ch_of[k]);
   end
`endif

endmodule

// File: tb/tb_dma_handshake_monitor.sv
// Directed self-checking bench for dma_handshake_monitor (NUM_CH=4, CNT_W=2, TIMEOUT=8).
// Inputs change 1 time unit after posedge; outputs are sampled at that same point.
module tb_dma_handshake_monitor;
   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 2;
   localparam int TIMEOUT = 8;

   logic                    clk = 1'b0;
   logic                    reset_n = 1'b0;
   logic [NUM_CH-1:0]       dreq = '0;
   logic [NUM_CH-1:0]       dack = '0;
   logic                    ior_n = 1'b1;
   logic                    iow_n = 1'b1;
   logic                    clr = 1'b0;
   logic [NUM_CH*CNT_W-1:0] req_cnt_bus, ack_cnt_bus;
   logic [4:0]              err_flags;
   logic                    err_valid;
   logic [2:0]              first_ch, first_code;

   int tests = 0;
   int fails = 0;

   dma_handshake_monitor #(
      .NUM_CH  (NUM_CH),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .CLK            (clk),
      .RESET_N        (reset_n),
      .DREQ           (dreq),
      .DACK           (dack),
      .IOR_N          (ior_n),
      .IOW_N          (iow_n),
      .CLR            (clr),
      .REQ_CNT        (req_cnt_bus),
      .ACK_CNT        (ack_cnt_bus),
      .ERR_FLAGS      (err_flags),
      .ERR_VALID      (err_valid),
      .FIRST_ERR_CH   (first_ch),
      .FIRST_ERR_CODE (first_code)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CNT_W-1:0] rq(input int i);
      return req_cnt_bus[i*CNT_W +: CNT_W];
   endfunction

   function automatic logic [CNT_W-1:0] ak(input int i);
      return ack_cnt_bus[i*CNT_W +: CNT_W];
   endfunction

   task automatic pulse_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      tests++; if (req_cnt_bus !== '0) begin fails++; $display("FAIL reset_req_cnt: got %0h want 0", req_cnt_bus); end
      tests++; if (ack_cnt_bus !== '0) begin fails++; $display("FAIL reset_ack_cnt: got %0h want 0", ack_cnt_bus); end
      tests++; if ({err_flags, err_valid, first_ch, first_code} !== 12'h000) begin
         fails++; $display("FAIL reset_err: flags %b valid %b ch %0d code %0d want all 0", err_flags, err_valid, first_ch, first_code);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_ch2_handshake();
      dreq = 4'b0100;
      repeat (3) tick();
      dack = 4'b0100;
      repeat (2) tick();
      dreq = '0;
      dack = '0;
      tick();
      tick();
      tests++; if (rq(2) !== 2'd1) begin fails++; $display("FAIL hs_req_cnt2: got %0d want 1", rq(2)); end
      tests++; if (ak(2) !== 2'd1) begin fails++; $display("FAIL hs_ack_cnt2: got %0d want 1", ak(2)); end
      tests++; if (err_flags !== 5'b00000) begin fails++; $display("FAIL hs_flags: got %b want 00000", err_flags); end
      tests++; if (rq(0) !== 2'd0 || ak(3) !== 2'd0) begin fails++; $display("FAIL hs_other_ch: req0 %0d ack3 %0d want 0 0", rq(0), ak(3)); end
   endtask

   task automatic test_ack_no_req();
      dack = 4'b0010;
      tick();
      dack = '0;
      tests++; if (err_valid !== 1'b1) begin fails++; $display("FAIL anr_valid: got %b want 1", err_valid); end
      tests++; if (err_flags !== 5'b00001) begin fails++; $display("FAIL anr_flags: got %b want 00001", err_flags); end
      tests++; if (first_ch !== 3'd1 || first_code !== 3'd0) begin fails++; $display("FAIL anr_first: ch %0d code %0d want 1 0", first_ch, first_code); end
      tick();
      tests++; if (err_valid !== 1'b0 || err_flags !== 5'b00001) begin fails++; $display("FAIL anr_sticky: valid %b flags %b want 0 00001", err_valid, err_flags); end
      pulse_clr();
      tests++; if (err_flags !== 5'b00000 || first_ch !== 3'd0) begin fails++; $display("FAIL anr_clr: flags %b ch %0d want 00000 0", err_flags, first_ch); end
   endtask

   task automatic test_timeout();
      int first_set = 0;
      int pulses = 0;
      dreq = 4'b1000;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (err_flags[3] && first_set == 0) first_set = t;
         if (err_valid) pulses++;
      end
      tests++; if (first_set !== 9) begin fails++; $display("FAIL to_when: flag set after tick %0d want 9", first_set); end
      tests++; if (pulses !== 1) begin fails++; $display("FAIL to_pulses: got %0d want 1", pulses); end
      tests++; if (first_ch !== 3'd3 || first_code !== 3'd3) begin fails++; $display("FAIL to_first: ch %0d code %0d want 3 3", first_ch, first_code); end
      dreq = '0;
      tick();
      tests++; if (err_flags !== 5'b11000 || err_valid !== 1'b1) begin fails++; $display("FAIL drop_flags: flags %b valid %b want 11000 1", err_flags, err_valid); end
      tests++; if (first_code !== 3'd3) begin fails++; $display("FAIL drop_first_kept: code %0d want 3", first_code); end
      tests++; if (rq(3) !== 2'd1 || ak(3) !== 2'd0) begin fails++; $display("FAIL to_cnt3: req %0d ack %0d want 1 0", rq(3), ak(3)); end
      pulse_clr();
   endtask

   task automatic test_multi_ack_io();
      dreq  = 4'b0011;
      dack  = 4'b0011;
      ior_n = 1'b0;
      iow_n = 1'b0;
      tick();
      dreq  = '0;
      dack  = '0;
      ior_n = 1'b1;
      iow_n = 1'b1;
      tests++; if (err_flags !== 5'b00110) begin fails++; $display("FAIL mio_flags: got %b want 00110", err_flags); end
      tests++; if (first_code !== 3'd1 || first_ch !== 3'd0) begin fails++; $display("FAIL mio_first: code %0d ch %0d want 1 0", first_code, first_ch); end
      tick();
      tests++; if (err_valid !== 1'b0 || err_flags !== 5'b00110) begin fails++; $display("FAIL mio_release: valid %b flags %b want 0 00110", err_valid, err_flags); end
      tests++; if (rq(0) !== 2'd1 || ak(1) !== 2'd1) begin fails++; $display("FAIL mio_cnt: req0 %0d ack1 %0d want 1 1", rq(0), ak(1)); end
      pulse_clr();
   endtask

   task automatic test_saturation_clr();
      for (int h = 0; h < 5; h++) begin
         dreq = 4'b0001; dack = 4'b0000; tick();
         dack = 4'b0001; tick();
         dreq = '0; dack = '0; tick();
         if (h == 1) begin
            tests++; if (rq(0) !== 2'd2 || ak(0) !== 2'd2) begin fails++; $display("FAIL sat_mid: req %0d ack %0d want 2 2", rq(0), ak(0)); end
         end
      end
      tests++; if (rq(0) !== 2'd3 || ak(0) !== 2'd3) begin fails++; $display("FAIL sat_end: req %0d ack %0d want 3 3", rq(0), ak(0)); end
      tests++; if (err_flags !== 5'b00000) begin fails++; $display("FAIL sat_flags: got %b want 00000", err_flags); end
      dreq = 4'b0100;
      tick();
      pulse_clr();
      tests++; if (req_cnt_bus !== '0 || ack_cnt_bus !== '0) begin fails++; $display("FAIL clr_cnt: req %0h ack %0h want 0 0", req_cnt_bus, ack_cnt_bus); end
      dack = 4'b0100;
      tick();
      tests++; if (ak(2) !== 2'd1 || rq(2) !== 2'd0) begin fails++; $display("FAIL clr_fsm_kept: ack2 %0d req2 %0d want 1 0", ak(2), rq(2)); end
      dreq = '0;
      dack = '0;
      tick();
      tests++; if (err_flags !== 5'b00000) begin fails++; $display("FAIL clr_fsm_flags: got %b want 00000", err_flags); end
   endtask

   task automatic test_clr_drop();
      ior_n = 1'b0;
      iow_n = 1'b0;
      clr   = 1'b1;
      tick();
      ior_n = 1'b1;
      iow_n = 1'b1;
      clr   = 1'b0;
      tests++; if (err_valid !== 1'b0 || err_flags !== 5'b00000) begin fails++; $display("FAIL clr_drop: valid %b flags %b want 0 00000", err_valid, err_flags); end
      tick();
      tests++; if (err_valid !== 1'b0 || first_code !== 3'd0) begin fails++; $display("FAIL clr_drop_late: valid %b code %0d want 0 0", err_valid, first_code); end
   endtask

   task automatic test_reset_mid();
      dreq  = 4'b0010;
      dack  = 4'b0010;
      ior_n = 1'b0;
      iow_n = 1'b0;
      tick();
      ior_n = 1'b1;
      iow_n = 1'b1;
      tests++; if (ak(1) !== 2'd1 || err_flags !== 5'b00100) begin fails++; $display("FAIL rm_pre: ack1 %0d flags %b want 1 00100", ak(1), err_flags); end
      reset_n = 1'b0;
      tick();
      tests++; if (req_cnt_bus !== '0 || ack_cnt_bus !== '0 || {err_flags, err_valid, first_ch, first_code} !== 12'h000) begin
         fails++; $display("FAIL rm_reset: req %0h ack %0h flags %b valid %b ch %0d code %0d want all 0",
                           req_cnt_bus, ack_cnt_bus, err_flags, err_valid, first_ch, first_code);
      end
      reset_n = 1'b1;
      dreq    = '0;
      dack    = '0;
      tick();
      tick();
      tests++; if (err_flags !== 5'b00000 || err_valid !== 1'b0) begin fails++; $display("FAIL rm_release: flags %b valid %b want 00000 0", err_flags, err_valid); end
      tests++; if (rq(1) !== 2'd0 || ak(1) !== 2'd0) begin fails++; $display("FAIL rm_cnt: req1 %0d ack1 %0d want 0 0", rq(1), ak(1)); end
   endtask

   initial begin
      test_reset();
      test_ch2_handshake();
      test_ack_no_req();
      test_timeout();
      test_multi_ack_io();
      test_saturation_clr();
      test_clr_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
